fetch_pair_queue: RTL and testbench
===================================

FETCH_PAIR_QUEUE -- requirements
Module: fetch_pair_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4 (power of two, >=2), giving the number of instruction-pair entries.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port push_valid, input, 1: fetch presents an instruction pair.
REQ-006 SHALL have port push_ready, output, 1: queue accepts a pair this cycle.
REQ-007 SHALL have ports pc1_in and pc2_in, input, WIDTH: slot PCs (pc2_in = pc1_in + 4 for a sequential pair).
REQ-008 SHALL have ports instr1_in and instr2_in, input, WIDTH: slot instruction words.
REQ-009 SHALL have port flush, input, 1: branch redirect from either execute pipeline.
REQ-010 SHALL have port issue_ready, input, 1: both decode stages can accept this cycle.
REQ-011 SHALL have ports issue_valid1 and issue_valid2, output, 1: slot 1 and slot 2 issue qualifiers.
REQ-012 SHALL have ports issue_pc1, issue_pc2, issue_instr1 and issue_instr2, output, WIDTH: issued PCs and instructions.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-014 SHALL store pairs in a circular buffer with head and tail pointers that wrap modulo DEPTH.
REQ-015 SHALL drive push_ready = (count != DEPTH) & ~flush; a push occurs on push_valid & push_ready.
REQ-016 SHALL make a pushed pair visible at the head no earlier than the cycle after the push (1-cycle latency).
REQ-017 SHALL drive issue outputs combinationally from the head entry; issue_pc/instr hold the head values even while the valid bits are low.
REQ-018 SHALL detect a hazard when instr1 writes a register and instr2 reads it: instr1[11:7] != 0, instr1[6:0] is neither 0100011 (store) nor 1100011 (branch), and instr1[11:7] equals instr2[19:15] or instr2[24:20].
REQ-019 SHALL implement FSM states PAIR (reset state) and SPLIT.
REQ-020 In PAIR with count>0 and no hazard: issue_valid1 = issue_valid2 = 1; on issue_ready, pop the head and stay in PAIR.
REQ-021 In PAIR with count>0 and a hazard: issue_valid1 = 1 and issue_valid2 = 0; on issue_ready, go to SPLIT without popping.
REQ-022 In SPLIT: issue_valid1 = 0 and issue_valid2 = 1; on issue_ready, pop the head and go to PAIR.
REQ-023 SHALL hold issue_valid1 = issue_valid2 = 0 whenever count = 0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; both pointers SHALL advance.
REQ-025 flush SHALL win over push, pop and FSM transitions: the next cycle has count = 0, head = tail and state PAIR, and the pushed pair is discarded.
REQ-026 A push with push_ready low SHALL be ignored with no state change.

Reset
REQ-027 On rst: count = 0, head = tail = 0, state = PAIR, push_ready = 0 in the reset cycle, and issue_valid1 = issue_valid2 = 0.
REQ-028 rst asserted mid-split SHALL abandon the pending slot 2 without issuing it.
REQ-029 Buffer storage SHALL not be reset; its contents are undefined until written.

Configuration
REQ-030 With macro FPQ_BYPASS_EN defined: when count = 0 and the state is PAIR, a push SHALL appear on the issue outputs in the same cycle using the REQ-020/021 rules. A bypassed pair fully consumed by issue_ready SHALL not be written.
REQ-031 With FPQ_BYPASS_EN undefined: there is no bypass and REQ-016 latency holds.

Verification
REQ-032 Reset, then push pc1=0x0, pc2=0x4, instr1=0x00500093 (addi x1,x0,5), instr2=0x00700113 (addi x2,x0,7), issue_ready=1 -> next cycle issue_valid1=1, issue_valid2=1, issue_pc1=0x0, issue_pc2=0x4; count returns to 0.
REQ-033 Push instr1=0x00500093 and instr2=0x00108133 (add x2,x1,x1) at pc 0x10/0x14, issue_ready=1 -> cycle A issue_valid1=1, issue_valid2=0, pc1=0x10; cycle A+1 issue_valid1=0, issue_valid2=1, pc2=0x14; then empty.
REQ-034 Push 4 pairs with issue_ready=0 -> count=4, push_ready=0; a 5th push is ignored. Raise issue_ready -> pairs issue in push order; pointers wrap on refill.
REQ-035 Assert flush with count=3, state SPLIT and push_valid=1 -> next cycle count=0, state PAIR, no issue_valid.
REQ-036 Assert rst in the SPLIT state -> next cycle count=0 and issue_valid2=0.
REQ-037 Build with FPQ_BYPASS_EN, push into an empty queue with issue_ready=1 -> issue_valid1=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: circular queue of fetched instruction pairs feeding two decode slots.
// A pair whose second instruction reads the first one's destination issues as two single slots.
// Optional macro FPQ_BYPASS_EN: a push into an empty queue in the PAIR state is shown on the
// issue outputs in the same cycle.
module fetch_pair_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         pc1_in,
    input  logic [WIDTH-1:0]         pc2_in,
    input  logic [WIDTH-1:0]         instr1_in,
    input  logic [WIDTH-1:0]         instr2_in,
    input  logic                     flush,
    input  logic                     issue_ready,
    output logic                     issue_valid1,
    output logic                     issue_valid2,
    output logic [WIDTH-1:0]         issue_pc1,
    output logic [WIDTH-1:0]         issue_pc2,
    output logic [WIDTH-1:0]         issue_instr1,
    output logic [WIDTH-1:0]         issue_instr2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {PAIR, SPLIT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc1_mem [DEPTH];
    logic [WIDTH-1:0] pc2_mem [DEPTH];
    logic [WIDTH-1:0] ins1_mem [DEPTH];
    logic [WIDTH-1:0] ins2_mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic             empty, push, pop, q_pop, wr, byp, have, hazard;
    logic [4:0]       rd1;
    logic [6:0]       op1;

    assign empty      = count == '0;
    assign push_ready = ~rst & ~flush & (count != FULL);
    assign push       = push_valid & push_ready;

`ifdef FPQ_BYPASS_EN
    assign byp = empty & (state == PAIR) & push;
`else
    assign byp = 1'b0;
`endif

    assign issue_pc1    = byp ? pc1_in    : pc1_mem[head];
    assign issue_pc2    = byp ? pc2_in    : pc2_mem[head];
    assign issue_instr1 = byp ? instr1_in : ins1_mem[head];
    assign issue_instr2 = byp ? instr2_in : ins2_mem[head];

    // slot 2 depends on slot 1 when slot 1 writes a nonzero rd that slot 2 reads
    always_comb begin
        rd1    = issue_instr1[11:7];
        op1    = issue_instr1[6:0];
        hazard = (rd1 != 5'd0) && (op1 != 7'b0100011) && (op1 != 7'b1100011) &&
                 ((rd1 == issue_instr2[19:15]) || (rd1 == issue_instr2[24:20]));
    end

    // output decode: slot qualifiers from state, occupancy and hazard
    always_comb begin
        have         = (~empty | byp) & ~rst;
        issue_valid1 = have & (state == PAIR);
        issue_valid2 = have & ((state == SPLIT) | ~hazard);
    end

    // the head leaves once slot 2 has been taken; a fully consumed bypass pair is never stored
    assign pop   = issue_ready & issue_valid2;
    assign q_pop = pop & ~empty;
    assign wr    = push & ~(byp & pop);

    // next state: split a hazard pair across two cycles, flush returns to PAIR
    always_comb begin
        state_next = flush ? PAIR :
                     (state == PAIR) ? ((issue_ready & issue_valid1 & ~issue_valid2) ? SPLIT : PAIR) :
                     ((issue_ready & issue_valid2) ? PAIR : SPLIT);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= PAIR;
        else
            state <= state_next;
    end

    // pointers and occupancy; flush empties the queue and drops any concurrent push
    always_ff @(posedge clk) begin
        if (rst | flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(q_pop);
            tail  <= tail + AW'(wr);
            count <= count + (AW+1)'(wr) - (AW+1)'(q_pop);
        end
    end

    // pair storage, left unreset
    always_ff @(posedge clk) begin
        if (wr) begin
            pc1_mem[tail]  <= pc1_in;
            pc2_mem[tail]  <= pc2_in;
            ins1_mem[tail] <= instr1_in;
            ins2_mem[tail] <= instr2_in;
        end
    end
endmodule

// File: tb/tb_fetch_pair_queue.sv
// tb_fetch_pair_queue: scoreboard bench for fetch_pair_queue
module tb_fetch_pair_queue;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;
`ifdef FPQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic         v1;
        logic         v2;
        logic [W-1:0] pc1;
        logic [W-1:0] pc2;
        logic [W-1:0] i1;
        logic [W-1:0] i2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0, flush = 1'b0, issue_ready = 1'b0;
    logic [W-1:0]  pc1_in = '0, pc2_in = '0, instr1_in = '0, instr2_in = '0;
    logic          push_ready, issue_valid1, issue_valid2;
    logic [W-1:0]  issue_pc1, issue_pc2, issue_instr1, issue_instr2;
    logic [CW-1:0] count;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_pair_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
        .pc1_in(pc1_in), .pc2_in(pc2_in), .instr1_in(instr1_in), .instr2_in(instr2_in),
        .flush(flush), .issue_ready(issue_ready),
        .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
        .issue_pc1(issue_pc1), .issue_pc2(issue_pc2),
        .issue_instr1(issue_instr1), .issue_instr2(issue_instr2), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hz(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] rd;
        rd = a[11:7];
        return (rd != 5'd0) && (a[6:0] != 7'b0100011) && (a[6:0] != 7'b1100011) &&
               ((rd == b[19:15]) || (rd == b[24:20]));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                            input bit acc);
        exp_t e;
        push_valid = 1'b1;
        pc1_in = pc;
        pc2_in = pc + 32'd4;
        instr1_in = a;
        instr2_in = b;
        #1;
        check("push_ready", push_ready, acc);
        if (acc) begin
            e.pc1 = pc;
            e.pc2 = pc + 32'd4;
            e.i1  = a;
            e.i2  = b;
            if (hz(a, b)) begin
                e.v1 = 1'b1; e.v2 = 1'b0; sbq.push_back(e);
                e.v1 = 1'b0; e.v2 = 1'b1; sbq.push_back(e);
            end else begin
                e.v1 = 1'b1; e.v2 = 1'b1; sbq.push_back(e);
            end
        end
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 40 && (sbq.size() != 0 || count != '0); i++) step();
        check({tag, "_cnt"}, count, 0);
        check({tag, "_sb"}, sbq.size(), 0);
    endtask

    // consumer: every accepted issue must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && !flush && issue_ready && (issue_valid1 || issue_valid2)) begin
            if (sbq.size() == 0) begin
                check("extra_issue", {issue_valid1, issue_valid2}, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("v1", issue_valid1, mon_e.v1);
                check("v2", issue_valid2, mon_e.v2);
                if (mon_e.v1) begin
                    check("pc1", issue_pc1, mon_e.pc1);
                    check("instr1", issue_instr1, mon_e.i1);
                end
                if (mon_e.v2) begin
                    check("pc2", issue_pc2, mon_e.pc2);
                    check("instr2", issue_instr2, mon_e.i2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog count=%0d pending=%0d", count, sbq.size());
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_push_ready", push_ready, 0);
        check("rst_v1", issue_valid1, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_cnt", count, 0);
        check("post_rst_v2", issue_valid2, 0);
        check("post_rst_ready", push_ready, 1);

        // independent pair, issued together
        issue_ready = 1'b1;
        set_push(32'h0, 32'h00500093, 32'h00700113, 1'b1);
        check("same_cycle_v1", issue_valid1, BYP);
        step();
        push_valid = 1'b0;
        check("cnt_after_push", count, BYP ? 0 : 1);
        wait_empty("pair");

        // dependent pair, split over two cycles
        set_push(32'h10, 32'h00500093, 32'h00108133, 1'b1);
        step();
        push_valid = 1'b0;
        wait_empty("split");

        // fill to capacity with the consumer stalled
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_push(32'h100 + 32'(k * 8), 32'h00500093 + (32'(k) << 20), 32'h00700113, 1'b1);
            step();
        end
        push_valid = 1'b0;
        #1;
        check("full_cnt", count, 4);
        check("full_ready", push_ready, 0);
        set_push(32'h1F0, 32'h00500093, 32'h00700113, 1'b0);
        step();
        push_valid = 1'b0;
        check("full_cnt2", count, 4);
        issue_ready = 1'b1;
        wait_empty("drain");

        // refill across the wrap point: branch exemption, rs2 hazard, rd=x0
        set_push(32'h200, 32'h00208463, 32'h008401B3, 1'b1);
        step();
        set_push(32'h208, 32'h00100413, 32'h008001B3, 1'b1);
        step();
        set_push(32'h210, 32'h00000013, 32'h00000033, 1'b1);
        step();
        push_valid = 1'b0;
        wait_empty("refill");

        // flush while split with three entries queued and a push offered
        issue_ready = 1'b0;
        set_push(32'h300, 32'h00500093, 32'h00108133, 1'b1);
        step();
        set_push(32'h308, 32'h00500093, 32'h00700113, 1'b1);
        step();
        set_push(32'h310, 32'h00000013, 32'h00000033, 1'b1);
        step();
        push_valid = 1'b0;
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("pre_flush_cnt", count, 3);
        check("pre_flush_v1", issue_valid1, 0);
        check("pre_flush_v2", issue_valid2, 1);
        flush = 1'b1;
        set_push(32'h400, 32'h00500093, 32'h00700113, 1'b0);
        step();
        flush = 1'b0;
        push_valid = 1'b0;
        sbq.delete();
        check("flush_cnt", count, 0);
        check("flush_v1", issue_valid1, 0);
        check("flush_v2", issue_valid2, 0);
        issue_ready = 1'b1;
        set_push(32'h500, 32'h00500093, 32'h00108133, 1'b1);
        step();
        push_valid = 1'b0;
        wait_empty("post_flush");

        // reset while split abandons slot 2
        issue_ready = 1'b0;
        set_push(32'h600, 32'h00100413, 32'h00040193, 1'b1);
        step();
        push_valid = 1'b0;
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("pre_rst_v2", issue_valid2, 1);
        rst = 1'b1;
        #1;
        check("rst_cycle_ready", push_ready, 0);
        step();
        rst = 1'b0;
        sbq.delete();
        check("mid_rst_cnt", count, 0);
        check("mid_rst_v2", issue_valid2, 0);

        // empty-queue push with consumer ready
        issue_ready = 1'b1;
        set_push(32'h700, 32'h00000013, 32'h00700113, 1'b1);
        check("byp_v1", issue_valid1, BYP);
        check("byp_v2", issue_valid2, BYP);
        step();
        push_valid = 1'b0;
        check("byp_cnt", count, BYP ? 0 : 1);
        wait_empty("byp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
